// File: rtl/game_sequencer.sv
// game_sequencer: top-level control FSM for the falling-block game.
//   Counts frame ticks, issues one shift_en or spawn_en per game step, then
//   scans the 16x32 cell display out to the VGA adapter as SCALE x SCALE
//   pixel blocks, and finally checks the datapath collide flag for game over.
//
// Ports:
//   clock, resetn            clock / async active-low reset
//   start                    one-cycle start/restart pulse (IDLE, OVER only)
//   pause                    level, freezes tick counting in WAIT
//   frame_tick               one-cycle pulse per frame
//   collide                  top-row overflow flag, sampled in DRAIN
//   cell_bit                 display bit, valid the cycle after cell_x/cell_y
//   cell_x, cell_y           cell address presented during the scan
//   shift_en, spawn_en       one-cycle step commands
//   plot, x, y, colour       VGA write port
//   busy, game_over          status
//
// Optional feature (macro CLEAR_ON_START_EN): start enters CLEAR, a full scan
// painting every pixel BG_COLOUR, followed by its own drain cycle, then WAIT.
module game_sequencer #(
  parameter int         TICKS_PER_STEP  = 16,
  parameter int         STEPS_PER_SPAWN = 16,
  parameter int         SCALE           = 2,
  parameter logic [2:0] FG_COLOUR       = 3'b010,
  parameter logic [2:0] BG_COLOUR       = 3'b001
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       start,
  input  logic       pause,
  input  logic       frame_tick,
  input  logic       collide,
  input  logic       cell_bit,
  output logic [3:0] cell_x,
  output logic [4:0] cell_y,
  output logic       shift_en,
  output logic       spawn_en,
  output logic       plot,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       busy,
  output logic       game_over
);

  localparam int TW = (TICKS_PER_STEP  > 1) ? $clog2(TICKS_PER_STEP)  : 1;
  localparam int SW = (STEPS_PER_SPAWN > 1) ? $clog2(STEPS_PER_SPAWN) : 1;
  localparam logic [TW-1:0] TLAST = TW'(TICKS_PER_STEP - 1);
  localparam logic [SW-1:0] SLAST = SW'(STEPS_PER_SPAWN - 1);
  localparam logic [1:0]    KLAST = 2'(SCALE - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_WAIT, S_SHIFT, S_SPAWN, S_DRAW, S_DRAIN, S_OVER
`ifdef CLEAR_ON_START_EN
    , S_CLEAR, S_CDRAIN
`endif
  } state_t;

`ifdef CLEAR_ON_START_EN
  localparam state_t START_ST = S_CLEAR;
`else
  localparam state_t START_ST = S_WAIT;
`endif

  state_t        state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [SW-1:0] step_q, step_d;
  logic          pend_q, pend_d;
  logic [3:0]    cx_q, cx_d;
  logic [1:0]    sx_q, sx_d;
  logic [4:0]    cy_q, cy_d;
  logic [1:0]    sy_q, sy_d;
  logic          plot_q, plot_d;
  logic [7:0]    x_q, x_d;
  logic [6:0]    y_q, y_d;
  logic          clr_q, clr_d;
  logic [2:0]    col_q;
  logic          scan, scan_last;

  assign scan_last = (sy_q == KLAST) && (cy_q == 5'd31) &&
                     (sx_q == KLAST) && (cx_q == 4'd15);

  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    step_d    = step_q;
    pend_d    = pend_q;
    cx_d      = cx_q;
    sx_d      = sx_q;
    cy_d      = cy_q;
    sy_d      = sy_q;
    plot_d    = 1'b0;
    x_d       = x_q;
    y_d       = y_q;
    clr_d     = clr_q;
    scan      = 1'b0;
    shift_en  = 1'b0;
    spawn_en  = 1'b0;
    busy      = 1'b0;
    game_over = 1'b0;

    // A tick arriving while the step/scan machinery is busy is remembered
    // (1 deep) so no frame is silently dropped between steps.
    if (frame_tick && state_q != S_IDLE && state_q != S_WAIT && state_q != S_OVER)
      pend_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = START_ST;
          tick_d  = '0;
          step_d  = '0;
          pend_d  = 1'b0;
        end
      end
      S_WAIT: begin
        if ((frame_tick || pend_q) && !pause) begin
          pend_d = 1'b0;
          if (tick_q == TLAST) begin
            tick_d  = '0;
            state_d = (step_q == SLAST) ? S_SPAWN : S_SHIFT;
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end
      S_SHIFT: begin
        shift_en = 1'b1;
        busy     = 1'b1;
        step_d   = step_q + SW'(1);
        state_d  = S_DRAW;
      end
      S_SPAWN: begin
        spawn_en = 1'b1;
        busy     = 1'b1;
        step_d   = '0;
        state_d  = S_DRAW;
      end
      S_DRAW: begin
        busy = 1'b1;
        scan = 1'b1;
        if (scan_last) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        // Final plot leaves the output register this cycle.
        busy    = 1'b1;
        state_d = collide ? S_OVER : S_WAIT;
      end
      S_OVER: begin
        game_over = 1'b1;
        if (start) begin
          state_d = START_ST;
          tick_d  = '0;
          step_d  = '0;
          pend_d  = 1'b0;
        end
      end
`ifdef CLEAR_ON_START_EN
      S_CLEAR: begin
        busy = 1'b1;
        scan = 1'b1;
        if (scan_last) state_d = S_CDRAIN;
      end
      S_CDRAIN: begin
        busy    = 1'b1;
        state_d = S_WAIT;
      end
`endif
      default: state_d = S_IDLE;
    endcase

    // Scan order, outermost first: cx, sx, cy, sy. Counters wrap to 0 on the
    // last address so the next scan starts clean.
    if (scan) begin
      plot_d = 1'b1;
      x_d    = 8'(cx_q) * 8'(SCALE) + 8'(sx_q);
      y_d    = 7'(cy_q) * 7'(SCALE) + 7'(sy_q);
`ifdef CLEAR_ON_START_EN
      clr_d  = (state_q == S_CLEAR);
`else
      clr_d  = 1'b0;
`endif
      sy_d = (sy_q == KLAST) ? 2'd0 : sy_q + 2'd1;
      if (sy_q == KLAST) begin
        cy_d = (cy_q == 5'd31) ? 5'd0 : cy_q + 5'd1;
        if (cy_q == 5'd31) begin
          sx_d = (sx_q == KLAST) ? 2'd0 : sx_q + 2'd1;
          if (sx_q == KLAST)
            cx_d = (cx_q == 4'd15) ? 4'd0 : cx_q + 4'd1;
        end
      end
    end
  end

  // cell_bit answers the previous cycle's address, so it lines up with the
  // registered plot/x/y stage; colour is resolved here and held afterwards.
  always_comb begin
    colour = col_q;
    if (plot_q) colour = (clr_q || !cell_bit) ? BG_COLOUR : FG_COLOUR;
  end

  assign plot   = plot_q;
  assign x      = x_q;
  assign y      = y_q;
  assign cell_x = cx_q;
  assign cell_y = cy_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      tick_q  <= '0;
      step_q  <= '0;
      pend_q  <= 1'b0;
      cx_q    <= '0;
      sx_q    <= '0;
      cy_q    <= '0;
      sy_q    <= '0;
      plot_q  <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      clr_q   <= 1'b0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      step_q  <= step_d;
      pend_q  <= pend_d;
      cx_q    <= cx_d;
      sx_q    <= sx_d;
      cy_q    <= cy_d;
      sy_q    <= sy_d;
      plot_q  <= plot_d;
      x_q     <= x_d;
      y_q     <= y_d;
      clr_q   <= clr_d;
      col_q   <= colour;
    end
  end

endmodule
